// File: rtl/lc3_pkg.sv
// Shared encodings and FSM state type for the LC-3 effective-address unit.
package lc3_pkg;

    localparam logic [1:0] ADDR2_OFF11 = 2'd0;
    localparam logic [1:0] ADDR2_OFF9  = 2'd1;
    localparam logic [1:0] ADDR2_OFF6  = 2'd2;
    localparam logic [1:0] ADDR2_ZERO  = 2'd3;

    localparam logic ADDR1_SR1 = 1'b0;
    localparam logic ADDR1_PC  = 1'b1;

    localparam logic MARMUX_SUM  = 1'b0;
    localparam logic MARMUX_TRAP = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IND_REQ = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/lc3_addr_adder.sv
// Combinational address datapath: addr1/addr2 select, sign extension,
// modulo-2^WIDTH add, and the MARMUX choice between sum and trap vector.
module lc3_addr_adder
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TRAPV_W = 8
) (
    input  logic [15:0]      instruction,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             marmux_sel,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] addr2;
    logic [WIDTH-1:0] trap_vec;
    logic             unused_opcode;

    // Opcode/register fields are not part of any offset.
    assign unused_opcode = ^instruction[15:11];

    assign trap_vec = {{(WIDTH-TRAPV_W){1'b0}}, instruction[TRAPV_W-1:0]};

    always_comb begin
        addr1 = (addr1_sel == ADDR1_PC) ? pc : sr1;
        addr2 = '0;
        case (addr2_sel)
            ADDR2_OFF11: addr2 = {{(WIDTH-11){instruction[10]}}, instruction[10:0]};
            ADDR2_OFF9:  addr2 = {{(WIDTH-9){instruction[8]}}, instruction[8:0]};
            ADDR2_OFF6:  addr2 = {{(WIDTH-6){instruction[5]}}, instruction[5:0]};
            default:     addr2 = '0;
        endcase
        // Carry out of the top bit is dropped: wrap-around is silent.
        sum    = addr1 + addr2;
        result = (marmux_sel == MARMUX_TRAP) ? trap_vec : sum;
    end

endmodule

// File: rtl/lc3_addr_unit.sv
// Registered, handshaked LC-3 effective-address unit with optional pointer
// dereference (LDI/STI) through a memory read port.
module lc3_addr_unit
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TRAPV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instruction,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             marmux_sel,
    input  logic             indirect,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] sum,
    output state_e           state
);

    // Handshake rule for both ports: a transfer happens on the rising clk edge
    // where valid and ready are both 1; the producer holds its payload stable
    // while valid=1 and ready=0. Only one request is in flight at a time.

    logic [WIDTH-1:0] adder_sum;
    logic [WIDTH-1:0] adder_result;
    state_e           state_q;
    state_e           state_d;
    logic             in_fire;
    logic             ack_fire;
    logic             deref;

    lc3_addr_adder #(
        .WIDTH   (WIDTH),
        .TRAPV_W (TRAPV_W)
    ) u_adder (
        .instruction (instruction),
        .pc          (pc),
        .sr1         (sr1),
        .addr1_sel   (addr1_sel),
        .addr2_sel   (addr2_sel),
        .marmux_sel  (marmux_sel),
        .sum         (adder_sum),
        .result      (adder_result)
    );

    // Trap vectors are never dereferenced here.
    assign deref    = indirect && (marmux_sel != MARMUX_TRAP);
    assign in_fire  = in_valid && (state_q == IDLE);
    assign ack_fire = mem_ack && (state_q == IND_REQ);
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = deref ? IND_REQ : DONE;
                end
            end
            IND_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            sum      <= '0;
            mem_addr <= '0;
        end else begin
            if (in_fire) begin
                sum <= adder_sum;
                if (deref) begin
                    mem_addr <= adder_result;
                end else begin
                    addr <= adder_result;
                end
            end
            if (ack_fire) begin
                addr <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lc3_addr_unit.sv
// Directed-vector bench for lc3_addr_unit: each task drives one scenario and
// compares DUT outputs against hand-computed values.
module tb_lc3_addr_unit;
    import lc3_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      instruction = '0;
    logic [WIDTH-1:0] pc = '0;
    logic [WIDTH-1:0] sr1 = '0;
    logic             addr1_sel = 1'b0;
    logic [1:0]       addr2_sel = 2'd3;
    logic             marmux_sel = 1'b0;
    logic             indirect = 1'b0;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack = 1'b0;
    logic [WIDTH-1:0] mem_rdata = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] sum;
    state_e           state;

    int checks = 0;
    int failures = 0;

    lc3_addr_unit #(.WIDTH(WIDTH), .TRAPV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc          (pc),
        .sr1         (sr1),
        .addr1_sel   (addr1_sel),
        .addr2_sel   (addr2_sel),
        .marmux_sel  (marmux_sel),
        .indirect    (indirect),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .addr        (addr),
        .sum         (sum),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Driver: present a request at a negedge, let the posedge take it, and
    // return at the following negedge with in_valid dropped.
    task automatic drive_req(input logic [15:0] ins, input logic [15:0] pcv,
                             input logic [15:0] srv, input logic a1,
                             input logic [1:0] a2, input logic mm, input logic ind);
        instruction = ins;
        pc          = pcv;
        sr1         = srv;
        addr1_sel   = a1;
        addr2_sel   = a2;
        marmux_sel  = mm;
        indirect    = ind;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({addr, sum, mem_addr} !== 48'h0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0", addr, sum, mem_addr); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_direct_pc();
        drive_req(16'h21FF, 16'h3001, 16'h0000, ADDR1_PC, ADDR2_OFF9, MARMUX_SUM, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL direct_latency out_valid got=%b exp=1", out_valid); end
        checks++; if (addr !== 16'h3000) begin failures++; $display("FAIL direct_addr got=%h exp=3000", addr); end
        checks++; if (sum !== 16'h3000) begin failures++; $display("FAIL direct_sum got=%h exp=3000", sum); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL direct_mem_req got=%b exp=0", mem_req); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL direct_in_ready got=%b exp=0", in_ready); end
        accept_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL direct_release got=%b%b exp=01", out_valid, in_ready); end
    endtask

    task automatic test_wrap();
        drive_req(16'h6041, 16'h0000, 16'hFFFF, ADDR1_SR1, ADDR2_OFF6, MARMUX_SUM, 1'b0);
        checks++; if (addr !== 16'h0000 || out_valid !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%h v=%b exp=0000 v=1", addr, out_valid); end
        accept_out();
        // Negative off6: 0x10 + (-32) = 0xFFF0
        drive_req(16'h6020, 16'h0000, 16'h0010, ADDR1_SR1, ADDR2_OFF6, MARMUX_SUM, 1'b0);
        checks++; if (addr !== 16'hFFF0) begin failures++; $display("FAIL off6_neg got=%h exp=fff0", addr); end
        accept_out();
    endtask

    task automatic test_trap();
        drive_req(16'hF025, 16'h3000, 16'h1111, ADDR1_PC, ADDR2_OFF9, MARMUX_TRAP, 1'b1);
        checks++; if (addr !== 16'h0025 || out_valid !== 1'b1) begin failures++; $display("FAIL trap_addr got=%h v=%b exp=0025 v=1", addr, out_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL trap_mem_req got=%b exp=0", mem_req); end
        accept_out();
    endtask

    task automatic test_indirect();
        drive_req(16'hA010, 16'h3000, 16'h0000, ADDR1_PC, ADDR2_OFF9, MARMUX_SUM, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3010) begin failures++; $display("FAIL ind_req_cyc%0d got=%b/%h exp=1/3010", c, mem_req, mem_addr); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ind_hs_cyc%0d got=%b%b exp=00", c, in_ready, out_valid); end
            if (c == 2) in_valid = 1'b1;
            if (c == 3) in_valid = 1'b0;
            if (c == 4) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h4000;
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        checks++; if (out_valid !== 1'b1 || addr !== 16'h4000) begin failures++; $display("FAIL ind_result got=%b/%h exp=1/4000", out_valid, addr); end
        checks++; if (sum !== 16'h3010) begin failures++; $display("FAIL ind_sum got=%h exp=3010", sum); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ind_mem_req_drop got=%b exp=0", mem_req); end
        accept_out();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ind_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        drive_req(16'h0000, 16'h0000, 16'h1234, ADDR1_SR1, ADDR2_ZERO, MARMUX_SUM, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            checks++; if (out_valid !== 1'b1 || addr !== 16'h1234 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_cyc%0d got=%b/%h/%b exp=1/1234/0", c, out_valid, addr, in_ready); end
            if (c == 2) begin
                drive_req(16'h21FF, 16'h5555, 16'h7777, ADDR1_PC, ADDR2_OFF9, MARMUX_SUM, 1'b0);
                mem_ack   = 1'b1;
                mem_rdata = 16'hBEEF;
            end else begin
                mem_ack = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        accept_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (sum !== 16'h1234 || addr !== 16'h1234) begin failures++; $display("FAIL bp_not_accepted got=%h/%h exp=1234/1234", sum, addr); end
    endtask

    task automatic test_back_to_back();
        // off11 = 0x400 = -1024: 0x3000 - 0x400 = 0x2C00
        drive_req(16'h4C00, 16'h3000, 16'h0000, ADDR1_PC, ADDR2_OFF11, MARMUX_SUM, 1'b0);
        checks++; if (addr !== 16'h2C00) begin failures++; $display("FAIL b2b_off11 got=%h exp=2c00", addr); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(16'h0000, 16'h0000, 16'h8001, ADDR1_SR1, ADDR2_ZERO, MARMUX_SUM, 1'b0);
        checks++; if (addr !== 16'h8001 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h v=%b exp=8001 v=1", addr, out_valid); end
        accept_out();
    endtask

    task automatic test_reset_mid_indirect();
        drive_req(16'hA010, 16'h3000, 16'h0000, ADDR1_PC, ADDR2_OFF9, MARMUX_SUM, 1'b1);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_req got=%b exp=1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_async_mem_req got=%b exp=0", mem_req); end
        checks++; if (state !== IDLE || in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_state got=%0d/%b exp=%0d/1", state, in_ready, IDLE); end
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rst_late_ack got=%b%b exp=00", out_valid, mem_req); end
        checks++; if (addr !== 16'h0000 || state !== IDLE) begin failures++; $display("FAIL rst_late_ack_addr got=%h/%0d exp=0000/%0d", addr, state, IDLE); end
    endtask

    initial begin
        test_reset();
        test_direct_pc();
        test_wrap();
        test_trap();
        test_indirect();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_indirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_addr_unit.md
Name: lc3_addr_unit

Overview:
- Registered, handshaked LC-3 effective-address unit.
- Computes base + sign-extended offset, or the zero-extended trap vector, and resolves indirect modes (LDI/STI) by fetching the pointer through a memory read port.
- Sits between the control FSM and the MAR/memory arbiter, replacing the purely combinational address adder path.
- Generalised in data width and in how long the memory response may take.

Parameters:
- WIDTH, 16, address/data width; must be >= 16; all offsets sign-extend to WIDTH.
- TRAPV_W, 8, trap-vector field width taken from instruction[TRAPV_W-1:0]; zero-extended.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- instruction  in  16  IR contents
- pc  in  WIDTH  incremented PC
- sr1  in  WIDTH  base register value
- addr1_sel  in  1  0 = sr1, 1 = pc
- addr2_sel  in  2  0 = off11, 1 = off9, 2 = off6, 3 = zero
- marmux_sel  in  1  0 = adder sum, 1 = trap vector
- indirect  in  1  1 = the result is a pointer and must be dereferenced
- mem_req  out  1  pointer read request
- mem_addr  out  WIDTH  pointer read address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  WIDTH  read data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- addr  out  WIDTH  final effective address
- sum  out  WIDTH  raw adder sum; in indirect mode this is the pointer location

Behaviour:
- Reset is asynchronous. Reset values:
  - state = IDLE, in_ready = 1, mem_req = 0, out_valid = 0
  - addr, sum, mem_addr = 0
- Arithmetic:
  - addr2 field is instruction[10:0], [8:0] or [5:0], sign-extended to WIDTH, or 0 when addr2_sel = 3.
  - sum = addr1 + addr2, modulo 2^WIDTH; wrap-around is silent with no carry out.
  - marmux_sel = 1 yields the zero-extended instruction[TRAPV_W-1:0] and ignores addr1/addr2.
- Handshakes:
  - A transfer occurs on the rising clk edge where valid & ready are both 1.
  - Inputs are sampled only on an input transfer.
  - Outputs hold stable while out_valid = 1 and out_ready = 0.
- FSM states: IDLE, IND_REQ, DONE.
  - IDLE: in_ready = 1. On an input transfer:
    - register the computed result into sum.
    - if indirect = 0 or marmux_sel = 1: addr = result, go to DONE.
    - otherwise: mem_addr = result, go to IND_REQ.
    - Trap vector is never dereferenced by this unit; indirect is ignored when marmux_sel = 1.
  - IND_REQ: mem_req = 1 with mem_addr stable until mem_ack.
    - On the mem_ack cycle: addr = mem_rdata, mem_req drops next cycle, go to DONE.
    - mem_ack may arrive in the first IND_REQ cycle (zero wait states) or after any number of cycles.
  - DONE: out_valid = 1.
    - On an output transfer, go to IDLE. in_ready = 1 from the following cycle.
    - No overlap: one request is in flight at a time.
- Latency, counted from the input transfer edge:
  - Direct: out_valid = 1 in the next cycle (1 cycle).
  - Indirect: mem_req = 1 in the next cycle; out_valid = 1 one cycle after the mem_ack edge. Minimum 2 cycles.
- in_ready = 0 in IND_REQ and DONE. in_valid in those states is ignored, not queued.
- mem_ack outside IND_REQ is ignored.
- Asserting rst_n low mid-operation abandons the transaction:
  - mem_req drops immediately (asynchronously).
  - A late mem_ack after reset release is ignored.

Decomposition:
- Shared package lc3_pkg holds:
  - ADDR2_OFF11 / OFF9 / OFF6 / ZERO encodings for addr2_sel
  - ADDR1_SR1 / ADDR1_PC
  - MARMUX_SUM / MARMUX_TRAP
  - the FSM state typedef
- One natural sub-module, lc3_addr_adder. It is combinational and parametrised by WIDTH and TRAPV_W. It implements the select/sign-extend/add/marmux datapath.
- The top level holds the FSM and registers.

Test Plan:
- Direct PC-relative, no wrap: pc = 0x3001, instr = 0x21FF (off9 = -1), addr1_sel = 1, addr2_sel = 1, marmux_sel = 0, indirect = 0.
  - Required: out_valid one cycle after the input transfer, addr = sum = 0x3000, mem_req never asserts.
- Direct with wrap: sr1 = 0xFFFF, instr off6 = +1 (0x6041), addr1_sel = 0, addr2_sel = 2.
  - Required: addr = 0x0000.
- Trap vector: instr = 0xF025, marmux_sel = 1, indirect = 1.
  - Required: addr = 0x0025 after 1 cycle, no mem_req.
- Indirect with 3 wait states: pc = 0x3000, off9 = +0x10, indirect = 1, mem_ack asserted on the 4th IND_REQ cycle with mem_rdata = 0x4000.
  - Required: mem_addr = 0x3010 held stable throughout, sum = 0x3010, addr = 0x4000, in_ready low throughout.
- Backpressure: out_ready = 0 for 5 cycles while in DONE, with in_valid pulsed during that time.
  - Required: addr stable, in_ready = 0, the pulsed request is not accepted; transfer completes when out_ready = 1.
- Reset mid-indirect: rst_n low during IND_REQ, then released, then mem_ack = 1.
  - Required: mem_req = 0 immediately, state IDLE, in_ready = 1, out_valid stays 0.
